// File: rtl/ghr_index_pkg.sv
// Sizing defaults and shared types for the global-history PHT index path.
// BPB_T / BPB_H / BPB_D set the index width, history width and checkpoint depth.
`ifndef BPB_T
`define BPB_T 4
`endif
`ifndef BPB_H
`define BPB_H `BPB_T
`endif
`ifndef BPB_D
`define BPB_D 4
`endif

package ghr_index_pkg;

    localparam int unsigned BPB_INDEX_WIDTH = `BPB_T;
    localparam int unsigned BPB_HIST_WIDTH  = `BPB_H;
    localparam int unsigned BPB_DEPTH       = `BPB_D;

    // Which value the speculative history takes at the next edge.
    typedef enum logic [1:0] {
        GHR_HOLD    = 2'd0,
        GHR_SHIFT   = 2'd1,
        GHR_RESTORE = 2'd2,
        GHR_REPAIR  = 2'd3
    } ghr_src_e;

    // Append one outcome bit as the youngest history bit, oldest bit falls off.
    function automatic logic [BPB_HIST_WIDTH-1:0] ghr_shift_default(
        input logic [BPB_HIST_WIDTH-1:0] hist,
        input logic                      outcome
    );
        return BPB_HIST_WIDTH'({hist, outcome});
    endfunction

endpackage

// File: rtl/ghr_fifo.sv
// Checkpoint circular buffer holding pre-shift history for each in-flight branch.
// Pointers wrap naturally because DEPTH is a power of two.
module ghr_fifo
    import ghr_index_pkg::*;
#(
    parameter int unsigned WIDTH = BPB_HIST_WIDTH,
    parameter int unsigned DEPTH = BPB_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head_ptr;
    logic [PW-1:0]    tail_ptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full & ~clear;
    assign pop_ok  = pop & ~empty & ~clear;
    assign head    = mem[head_ptr];

    // Storage needs no reset: entries are only read while the count covers them.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[tail_ptr] <= data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push_ok) begin
                tail_ptr <= tail_ptr + PW'(1);
            end
            if (pop_ok) begin
                head_ptr <= head_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ghr_index.sv
// PHT index generator: speculative GHR with per-branch checkpoints and repair.
// BPB_GSHARE_EN defined hashes the GHR into index_o; undefined gives a bimodal index.
module ghr_index
    import ghr_index_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = BPB_INDEX_WIDTH,
    parameter int unsigned HIST_WIDTH  = BPB_HIST_WIDTH,
    parameter int unsigned DEPTH       = BPB_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic [31:0]            pc_i,
    input  logic                   is_branch_i,
    input  logic                   pred_taken_i,
    output logic [INDEX_WIDTH-1:0] index_o,
    output logic                   full_o,
    input  logic                   resolve_valid_i,
    input  logic                   resolve_taken_i,
    input  logic                   mispredict_i,
    input  logic                   flush_i,
    output logic [HIST_WIDTH-1:0]  history_o
);

    logic [HIST_WIDTH-1:0] ghr;
    logic [HIST_WIDTH-1:0] ghr_next;
    logic [HIST_WIDTH-1:0] head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  resolve;
    logic                  repair;
    logic                  flushing;
    logic                  restore;
    logic                  push;
    logic                  pop;
    logic                  clear;
    ghr_src_e              src;

    ghr_fifo #(
        .WIDTH (HIST_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .data  (ghr),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Priority: mispredict repair > flush > push / correct resolve.
    always_comb begin
        resolve  = en_i & resolve_valid_i & ~fifo_empty;
        repair   = resolve & mispredict_i;
        flushing = en_i & flush_i & ~repair;
        restore  = flushing & ~fifo_empty;
        push     = en_i & is_branch_i & ~fifo_full & ~repair & ~flushing;
        pop      = resolve & ~repair & ~flushing;
        clear    = repair | restore;
        src      = GHR_HOLD;
        if (repair) begin
            src = GHR_REPAIR;
        end else if (restore) begin
            src = GHR_RESTORE;
        end else if (push) begin
            src = GHR_SHIFT;
        end
    end

    always_comb begin
        ghr_next = ghr;
        case (src)
            GHR_SHIFT:   ghr_next = HIST_WIDTH'({ghr, pred_taken_i});
            GHR_RESTORE: ghr_next = head;
            GHR_REPAIR:  ghr_next = HIST_WIDTH'({head, resolve_taken_i});
            default:     ghr_next = ghr;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ghr <= '0;
        end else begin
            ghr <= ghr_next;
        end
    end

    assign full_o    = fifo_full;
    assign history_o = ghr;

`ifdef BPB_GSHARE_EN
    assign index_o = pc_i[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(ghr);
`else
    assign index_o = pc_i[INDEX_WIDTH+1:2];
`endif

    // PC bits outside the index window are intentionally ignored.
    logic unused_pc;
    assign unused_pc = ^{pc_i[31:INDEX_WIDTH+2], pc_i[1:0]};

endmodule

// File: doc/ghr_index.md
Name: ghr_index

Overview:
- Global-history index generator sitting directly upstream of the pattern history table in the fetch stage.
- Produces the PHT index each cycle from the fetch PC and a speculative global history register (GHR).
- Shifts the PHT's prediction into the GHR and checkpoints pre-shift history per in-flight branch.
- Repairs the GHR from the checkpoint when decode reports a misprediction.

Parameters:
INDEX_WIDTH, `BPB_T, width of PHT index output
HIST_WIDTH, `BPB_H (default equal to `BPB_T), GHR width; must be <= INDEX_WIDTH
DEPTH, `BPB_D (default 4), max in-flight unresolved branches (checkpoint FIFO entries); power of two

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, asynchronous, active-high
en_i  input  1  pipeline advance enable; all state updates gated by it, except reset
pc_i  input  32  fetch PC
is_branch_i  input  1  fetch slot holds a conditional branch
pred_taken_i  input  1  PHT prediction (PHT taken_o) for the current fetch
index_o  output  INDEX_WIDTH  PHT index (to PHT index_i)
full_o  output  1  checkpoint FIFO full; fetch must stall branches
resolve_valid_i  input  1  decode resolves oldest in-flight branch
resolve_taken_i  input  1  actual direction of resolved branch
mispredict_i  input  1  resolved branch was mispredicted; qualified by resolve_valid_i
flush_i  input  1  pipeline flush (exception/redirect not caused by a branch)
history_o  output  HIST_WIDTH  current speculative GHR (debug/visibility)

Behaviour:
- index_o is combinational, valid in the same cycle as pc_i. It is pc_i[INDEX_WIDTH+1:2] XOR the zero-extended GHR, with GHR aligned to the low bits.
- GHR update is registered: the new history is visible on index_o the cycle after the push.
- Push: when en_i & is_branch_i & ~full_o:
  - FIFO tail <= current GHR (pre-shift);
  - GHR <= {GHR[HIST_WIDTH-2:0], pred_taken_i}.
- Branch while full: no push, no GHR shift. The upstream must hold the fetch; the branch is re-presented with the same pc_i.
- Resolve: when en_i & resolve_valid_i & FIFO non-empty, pop the head.
  - If mispredict_i: GHR <= {head[HIST_WIDTH-2:0], resolve_taken_i}, and the FIFO is cleared (all younger entries are wrong-path).
  - Else: GHR unchanged.
- Resolve with FIFO empty: ignored; no state change.
- Push and correct resolve in the same cycle: both occur; count unchanged; full_o stays as it was.
- Push and mispredict resolve in the same cycle: mispredict wins; the push is dropped and the GHR is taken from the repair value.
- Flush: when en_i & flush_i:
  - FIFO non-empty: GHR <= FIFO head, FIFO cleared.
  - FIFO empty: GHR unchanged.
  - Flush has priority over push and over a correct resolve. Mispredict resolve has priority over flush.
- FIFO implementation:
  - Circular buffer with head/tail pointers of clog2(DEPTH) bits plus a count of clog2(DEPTH)+1 bits.
  - Pointers wrap modulo DEPTH.
  - full_o = (count == DEPTH); registered-state-derived, no combinational path from inputs.
- Reset (asserts anytime, including mid-operation): GHR=0, FIFO empty, pointers=0, full_o=0. As a result, index_o = pc_i[INDEX_WIDTH+1:2] and history_o=0 immediately.
- en_i low: all state frozen; index_o still tracks pc_i.

Optional Feature:
BPB_GSHARE_EN
- Defined: index_o = PC bits XOR GHR (gshare), as above.
- Undefined: index_o = pc_i[INDEX_WIDTH+1:2] only (bimodal). The GHR, FIFO, full_o and history_o still operate identically, so repair logic is verifiable in both builds.

Decomposition:
- bpb.svh gains BPB_H and BPB_D next to the existing BPB_T.
- Sub-module ghr_fifo holds the checkpoint circular buffer:
  - inputs: push, pop, clear, data in;
  - outputs: head data, full, empty.
- ghr_index keeps the GHR register, priority logic and index hash.

Test Plan:
1. Reset, pc_i=0x0000_0040, INDEX_WIDTH=4 -> index_o=0x0, history_o=0; three predicted-taken branches -> history_o=0b111; index for pc 0x40 = 0x7 (gshare).
2. Push 4 branches (DEPTH=4) -> full_o=1; 5th branch held 3 cycles -> GHR and count unchanged; correct resolve -> full_o=0, 5th branch pushes next cycle.
3. GHR=0b0000, push T,T,N -> GHR=0b0110; mispredict resolve with resolve_taken_i=0 -> GHR=0b0000, FIFO empty.
4. Same cycle push(pred 1) + mispredict resolve(actual 1) with head 0b0101 -> GHR=0b1011, count 0.
5. Two branches pushed from GHR=0b0011, flush_i -> GHR=0b0011, FIFO empty; resolve_valid_i on empty -> no change.
6. Assert rst_i asynchronously mid-cycle with FIFO at count 3 -> history_o=0, full_o=0 before the next edge; build without BPB_GSHARE_EN -> index_o ignores GHR.
